// File: rtl/lc3b_types.sv
// ============================================================================
// Module   : lc3b_types (package)
// Brief    : Shared LC-3b memory-port types and the data responder FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  // Wait-state counter width; holds LATENCY-1 for LATENCY up to 15.
  localparam int CNT_BITS = 4;

  // A full-word access whose byte address is odd cannot be served as one word.
  function automatic logic is_misaligned(input logic addr_lsb, input lc3b_mem_wmask be);
    return (be == 2'b11) && addr_lsb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_word_array.sv
// ============================================================================
// Module   : dmem_word_array
// Brief    : 2**ADDR_BITS x 16 storage, synchronous byte-enabled write,
//            combinational read, no reset (contents survive reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_word_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  lc3b_word             wdata_i,
  input  lc3b_mem_wmask        be_i,
  output lc3b_word             rdata_o
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  lc3b_word mem_q [DEPTH];

  // Byte-lane write: only enabled bytes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we_i) begin
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory responder for the MEM stage. Accepts one
//            read/write request, waits LATENCY-1 cycles, pulses mem_resp for
//            one cycle. Writes commit at the edge ending the response cycle.
// Options  : DMEM_ALIGN_CHECK_EN - flag odd-address full-word accesses on
//            mem_error and suppress their effect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          mem_error
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  dmem_state_t          state_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  lc3b_word             wdata_q;
  lc3b_mem_wmask        be_q;
  logic                 write_q;
  lc3b_word             rdata_q;
  logic                 resp_q;

  logic                 req_w;
  logic                 cur_write_w;
  logic                 cur_mis_w;
  logic                 enter_resp_w;
  logic [ADDR_BITS-1:0] arr_addr_w;
  logic                 arr_we_w;
  lc3b_word             arr_rdata_w;

  // Only the word-index bits select storage; the rest alias or pick a lane.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  assign req_w = mem_read | mem_write;

  // In IDLE the request is still on the inputs; afterwards the latched copy rules.
  assign cur_write_w = (state_q == IDLE) ? mem_write : write_q;
  assign arr_addr_w  = (state_q == IDLE) ? mem_address[ADDR_BITS:1] : addr_q;

  // LATENCY=1 goes straight from IDLE to RESP, so the read must be taken there.
  assign enter_resp_w = ((state_q == IDLE) && req_w && (LATENCY == 1)) ||
                        ((state_q == BUSY) && (cnt_q == CNT_ONE));

`ifdef DMEM_ALIGN_CHECK_EN
  logic misal_q;
  logic error_q;
  assign cur_mis_w = (state_q == IDLE) ? is_misaligned(mem_address[0], mem_byte_enable)
                                       : misal_q;
  assign mem_error = error_q;
`else
  assign cur_mis_w = 1'b0;
  assign mem_error = 1'b0;
`endif

  // Write lands at the clock edge that ends RESP, before any new acceptance.
  assign arr_we_w = (state_q == RESP) && write_q && !cur_mis_w;

  dmem_word_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we_w),
    .addr_i  (arr_addr_w),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (arr_rdata_w)
  );

  // Request sequencer: accept, count wait states, pulse response, back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      misal_q <= 1'b0;
      error_q <= 1'b0;
`endif
    end else begin
      resp_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      error_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_w) begin
            addr_q  <= mem_address[ADDR_BITS:1];
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
            write_q <= mem_write;
            cnt_q   <= CNT_LOAD;
`ifdef DMEM_ALIGN_CHECK_EN
            misal_q <= is_misaligned(mem_address[0], mem_byte_enable);
`endif
            state_q <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (enter_resp_w) begin
        resp_q <= 1'b1;
        if (!cur_write_w && !cur_mis_w) rdata_q <= arr_rdata_w;
`ifdef DMEM_ALIGN_CHECK_EN
        error_q <= cur_mis_w;
`endif
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM-stage data port. It services the requests issued by the pipeline's indirect (LDI/STI) sequencing logic and by ordinary loads and stores.
- It accepts a single read or write request, waits a fixed number of wait states, then performs the access on an internal byte-enabled word array.
- It pulses mem_resp for exactly one cycle. It is the stand-in for the data cache in pipeline-level simulation and bring-up.

Parameters:
- ADDR_BITS, 8, number of word-index bits; array depth = 2**ADDR_BITS 16-bit words.
- LATENCY, 2, cycles from request acceptance to mem_resp. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- mem_read  input  1  read request; held by the initiator until mem_resp.
- mem_write  input  1  write request; held by the initiator until mem_resp.
- mem_address  input  16  byte address (lc3b_word).
- mem_wdata  input  16  write data (lc3b_word).
- mem_byte_enable  input  2  lc3b_mem_wmask; [1] = high byte, [0] = low byte.
- mem_rdata  output  16  read data.
- mem_resp  output  1  one-cycle completion pulse.
- mem_error  output  1  alignment error flag; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - state=IDLE, mem_resp=0, mem_rdata=16'h0000, mem_error=0, wait counter=0.
  - Array contents are NOT reset.
  - Reset mid-access aborts the access: no write is committed and no mem_resp is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read|mem_write is sampled high, latch address, wdata, byte_enable and op.
  - op = write if mem_write=1, else read. Write wins when both are high.
  - Load counter = LATENCY-1. Next state = RESP if LATENCY=1, else BUSY.
- BUSY: decrement the counter each cycle; when counter==1, next state = RESP.
- RESP:
  - mem_resp=1 for exactly this one cycle. Next state is always IDLE.
  - Reads: mem_rdata is registered and valid in the RESP cycle.
  - Writes: the array is updated at the clock edge ending RESP. Only enabled bytes change; byte_enable=2'b00 writes nothing but still responds.
- Latency: a request sampled at edge t gives mem_resp high in cycle t+LATENCY.
- Throughput: minimum spacing between accepted requests is LATENCY+1 cycles.
- RESP→IDLE is mandatory. A request still high in the cycle after mem_resp is treated as a NEW request. This is how the second (pointer-target) phase of LDI/STI gets served.
- Input changes after acceptance are ignored; the latched values are used. Request deassertion mid-access does not cancel it; mem_resp still pulses.
- mem_rdata holds its last read value through writes and idle cycles; it updates only in the RESP cycle of a read.
- Addressing:
  - word index = mem_address[ADDR_BITS:1].
  - mem_address[0] is ignored (the byte lane is selected by byte_enable).
  - Upper address bits alias (wrap-around), with no error.
- Read-after-write to the same word in back-to-back accesses returns the newly written data, because the write commits before the next acceptance.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined:
  - A request with mem_byte_enable=2'b11 and mem_address[0]=1 is a misaligned word access.
  - It still completes with normal latency and mem_resp, and mem_error=1 in the RESP cycle (0 otherwise).
  - A misaligned write commits nothing; a misaligned read leaves mem_rdata unchanged.
- When undefined: mem_error is constant 0, and misaligned accesses behave as aligned accesses to the word index.

Decomposition:
- lc3b_types package holds lc3b_word, lc3b_mem_wmask, and a new enum dmem_state_t {IDLE, BUSY, RESP}.
- Sub-module dmem_word_array: a 2**ADDR_BITS x 16 array with a synchronous byte-enabled write port and a combinational read port, with no reset.
- The FSM, counter and output registers stay in dmem_responder.

Test Plan:
- Reset, then write addr 16'h0010, wdata 16'hBEEF, be 2'b11, LATENCY=2 → mem_resp high exactly 2 cycles after acceptance, one cycle wide. A later read of 16'h0010 returns 16'hBEEF.
- Byte write: word 16'h0010 = 16'hBEEF, then write 16'h0011 with be=2'b10 and wdata 16'h12xx → read returns 16'h12EF.
- LDI-style hold: mem_read held high across mem_resp, address 16'h0020 (holds 16'h0040) then switched to 16'h0040 (holds 16'h5A5A) → two resp pulses spaced LATENCY+1 cycles, rdata 16'h0020-content then 16'h5A5A.
- Simultaneous mem_read=1 and mem_write=1, addr 16'h0030, wdata 16'h1234 → treated as a write; a subsequent read returns 16'h1234.
- Assert reset_n=0 in the BUSY state of a write to 16'h0050 (prior content 16'h0000) → mem_resp never pulses; a later read of 16'h0050 returns 16'h0000.
- With DMEM_ALIGN_CHECK_EN: write be=2'b11 to 16'h0061 → mem_resp=1 and mem_error=1 in the same cycle; word 16'h0060 is unchanged.
